// File: rtl/csr_pkg_ysyx.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, csr_op encodings, mcause codes and mstatus/mie/mip bit positions.
package csr_pkg_ysyx;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        TRAP_RUN   = 1'b0,
        TRAP_REDIR = 1'b1
    } trap_state_e;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIP_MTIP_BIT     = 7;

    // Vectored mode places the timer interrupt entry at base + 4*cause.
    localparam int MTVEC_MTI_OFFSET = 4 * 7;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running/event counter built from two halves; a software write to
// either half replaces it and suppresses the increment for that cycle.
module csr_counter64 #(
    parameter int HALF_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                wr_lo,
    input  logic                wr_hi,
    input  logic [HALF_W-1:0]   wdata,
    output logic [2*HALF_W-1:0] count
);

    logic [HALF_W-1:0] lo_reg;
    logic [HALF_W-1:0] hi_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_reg <= '0;
            hi_reg <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) lo_reg <= wdata;
            if (wr_hi) hi_reg <= wdata;
        end else if (inc) begin
            lo_reg <= lo_reg + 1'b1;
            if (&lo_reg) hi_reg <= hi_reg + 1'b1;
        end
    end

    assign count = {hi_reg, lo_reg};

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer with a registered one-cycle redirect.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_unit
    import csr_pkg_ysyx::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800,
    parameter logic [XLEN-1:0] MTVEC_RST   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            irq_timer_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            illegal_o,
    output logic            kill_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    logic            mstatus_mie_reg;
    logic            mstatus_mpie_reg;
    logic            mie_mtie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    trap_state_e     state_reg;
    trap_state_e     state_next;

    logic            accept;
    logic            irq_pending;
    logic            take_irq;
    logic            take_ecall;
    logic            take_mret;
    logic            trap_event;
    logic            csr_legal;
    logic            csr_we;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_val;
    logic [63:0] minstret_val;

    csr_counter64 #(.HALF_W(32)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (csr_we && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi (csr_we && (csr_addr_i == CSR_MCYCLEH)),
        .wdata (csr_new[31:0]),
        .count (mcycle_val)
    );

    csr_counter64 #(.HALF_W(32)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && !take_irq && !ecall_i),
        .wr_lo (csr_we && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi (csr_we && (csr_addr_i == CSR_MINSTRETH)),
        .wdata (csr_new[31:0]),
        .count (minstret_val)
    );
`endif

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie_reg;
        mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie_reg;
        mip_val = '0;
        mip_val[MIP_MTIP_BIT] = irq_timer_i;
    end

    always_comb begin
        csr_old   = '0;
        csr_legal = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_old = mstatus_val;
            CSR_MIE:       csr_old[MIE_MTIE_BIT] = mie_mtie_reg;
            CSR_MTVEC:     csr_old = mtvec_reg;
            CSR_MEPC:      csr_old = mepc_reg;
            CSR_MCAUSE:    csr_old = mcause_reg;
            CSR_MIP:       csr_old = mip_val;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_old = XLEN'(mcycle_val[31:0]);
            CSR_MCYCLEH:   csr_old = XLEN'(mcycle_val[63:32]);
            CSR_MINSTRET:  csr_old = XLEN'(minstret_val[31:0]);
            CSR_MINSTRETH: csr_old = XLEN'(minstret_val[63:32]);
`endif
            default:       csr_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            CSR_OP_RW: csr_new = csr_wdata_i;
            CSR_OP_RS: csr_new = csr_old | csr_wdata_i;
            CSR_OP_RC: csr_new = csr_old & ~csr_wdata_i;
            default:   csr_new = csr_old;
        endcase
    end

    assign csr_rdata_o = csr_old;
    assign illegal_o   = (csr_op_i != CSR_OP_NONE) && !csr_legal;

    // Priority: interrupt > ecall > mret > CSR write.
    assign accept      = valid_i && (state_reg == TRAP_RUN);
    assign irq_pending = irq_timer_i && mie_mtie_reg && mstatus_mie_reg;
    assign take_irq    = accept && irq_pending;
    assign take_ecall  = accept && !irq_pending && ecall_i;
    assign take_mret   = accept && !irq_pending && !ecall_i && mret_i;
    assign trap_event  = take_irq || take_ecall || take_mret;
    assign kill_o      = take_irq;

    // RS/RC with a zero mask must not write (no side effects on read-only CSRs).
    assign csr_we = accept && !irq_pending && !ecall_i && !mret_i
                 && (csr_op_i != CSR_OP_NONE) && csr_legal && (csr_addr_i != CSR_MIP)
                 && ((csr_op_i == CSR_OP_RW) || (csr_wdata_i != '0));

    always_comb begin
        trap_base = {mtvec_reg[XLEN-1:2], 2'b00};
        if (take_mret)
            trap_target = mepc_reg;
        else if (take_irq && (mtvec_reg[1:0] == 2'b01))
            trap_target = trap_base + XLEN'(MTVEC_MTI_OFFSET);
        else
            trap_target = trap_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_reg  <= MSTATUS_RST[MSTATUS_MIE_BIT];
            mstatus_mpie_reg <= MSTATUS_RST[MSTATUS_MPIE_BIT];
            mie_mtie_reg     <= 1'b0;
            mtvec_reg        <= MTVEC_RST;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
        end else if (take_irq || take_ecall) begin
            mepc_reg         <= pc_i;
            mcause_reg       <= take_irq ? XLEN'(CAUSE_MTI) : XLEN'(CAUSE_ECALL_M);
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (take_mret) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_reg  <= csr_new[MSTATUS_MIE_BIT];
                    mstatus_mpie_reg <= csr_new[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:    mie_mtie_reg <= csr_new[MIE_MTIE_BIT];
                CSR_MTVEC:  mtvec_reg    <= csr_new;
                CSR_MEPC:   mepc_reg     <= {csr_new[XLEN-1:2], 2'b00};
                CSR_MCAUSE: mcause_reg   <= csr_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_reg <= '0;
        end else if (trap_event) begin
            redirect_pc_reg <= trap_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= TRAP_RUN;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TRAP_RUN:   if (trap_event) state_next = TRAP_REDIR;
            TRAP_REDIR: state_next = TRAP_RUN;
            default:    state_next = TRAP_RUN;
        endcase
    end

    always_comb begin
        redirect_o    = (state_reg == TRAP_REDIR);
        redirect_pc_o = redirect_pc_reg;
    end

endmodule
